// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue front end and the execute stage:
// ALU op codes, ISA opcodes, instruction field positions and the decoded bundle.
package decode_issue_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned REG_IDX_W  = 3;

  // Instruction field positions
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned RT_LSB  = 5;
  localparam int unsigned RD_LSB  = 2;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned FN_W    = 2;
  localparam int unsigned IMM5_W  = 5;
  localparam int unsigned IMM8_W  = 8;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_SEQ  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLE  = 4'd6,
    ALU_SCO  = 4'd7,
    ALU_ROL  = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_ROR  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_ANDN = 4'd12,
    ALU_SLB  = 4'd13,
    ALU_BTR  = 4'd14
  } alu_op_e;

  // ISA opcodes; the wildcard entries are matched with casez
  localparam logic [OPC_W-1:0] OPC_NOP     = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_IMM     = 5'b010??;
  localparam logic [OPC_W-1:0] OPC_SLBI    = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_BTR     = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_R_SHIFT = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_R_ALU   = 5'b11011;
  localparam logic [OPC_W-1:0] OPC_SET     = 5'b111??;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } occ_state_e;

  typedef struct packed {
    alu_op_e                op;
    logic [DATA_WIDTH-1:0]  data1;
    logic [DATA_WIDTH-1:0]  data2;
    logic [REG_IDX_W-1:0]   dest;
    logic                   wr_en;
    logic                   illegal;
  } bundle_t;

  // R-ALU fn and immediate-ALU opcode LSBs share one mapping: ADD/SUB/XOR/ANDN
  function automatic alu_op_e alu_family(input logic [1:0] sel);
    case (sel)
      2'd0:    alu_family = ALU_ADD;
      2'd1:    alu_family = ALU_SUB;
      2'd2:    alu_family = ALU_XOR;
      default: alu_family = ALU_ANDN;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Instruction-in / bundle-out handshake plus the writeback port of decode_issue.
// master = surrounding pipeline, slave = the decoder.
interface decode_issue_if;
  import decode_issue_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] instr;

  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic [REG_IDX_W-1:0]  dest;
  logic                  wr_en;
  logic                  illegal;

  logic                  wb_en;
  logic [REG_IDX_W-1:0]  wb_reg;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    output in_valid, instr, out_ready, wb_en, wb_reg, wb_data,
    input  in_ready, out_valid, op, data1, data2, dest, wr_en, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready, wb_en, wb_reg, wb_data,
    output in_ready, out_valid, op, data1, data2, dest, wr_en, illegal
  );

endinterface

// File: rtl/decode_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write port.
// With DECODE_BYPASS_EN defined, a same-cycle write is forwarded to the read ports.
module decode_regfile
  import decode_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] rd_addr1,
  input  logic [REG_IDX_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]    rd_data1,
  output logic [DATA_W-1:0]    rd_data2,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]    wb_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[wb_reg] <= wb_data;
    end
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
`ifdef DECODE_BYPASS_EN
    if (wb_en && (wb_reg == rd_addr1)) rd_data1 = wb_data;
    if (wb_en && (wb_reg == rd_addr2)) rd_data2 = wb_data;
`endif
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes one instruction per handshake into an ALU bundle held
// in a single registered output slot. Optional write-through: DECODE_BYPASS_EN.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_issue_if.slave  bus
);

  logic [OPC_W-1:0]     opc;
  logic [REG_IDX_W-1:0] rs;
  logic [REG_IDX_W-1:0] rt;
  logic [REG_IDX_W-1:0] rd;
  logic [FN_W-1:0]      fn;
  logic [IMM5_W-1:0]    imm5;
  logic [IMM8_W-1:0]    imm8;

  assign opc  = bus.instr[OPC_LSB +: OPC_W];
  assign rs   = bus.instr[RS_LSB  +: REG_IDX_W];
  assign rt   = bus.instr[RT_LSB  +: REG_IDX_W];
  assign rd   = bus.instr[RD_LSB  +: REG_IDX_W];
  assign fn   = bus.instr[FN_LSB  +: FN_W];
  assign imm5 = bus.instr[0 +: IMM5_W];
  assign imm8 = bus.instr[0 +: IMM8_W];

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  decode_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rs),
    .rd_addr2 (rt),
    .rd_data1 (rs_val),
    .rd_data2 (rt_val),
    .wb_en    (bus.wb_en),
    .wb_reg   (bus.wb_reg),
    .wb_data  (bus.wb_data)
  );

  bundle_t dec_b;

  always_comb begin
    dec_b = '0;
    casez (opc)
      OPC_R_ALU: begin
        dec_b.op    = alu_family(fn);
        dec_b.data1 = rs_val;
        dec_b.data2 = rt_val;
        dec_b.dest  = rd;
        dec_b.wr_en = 1'b1;
      end
      OPC_R_SHIFT: begin
        dec_b.op    = alu_op_e'({2'b10, fn});
        dec_b.data1 = rs_val;
        dec_b.data2 = rt_val;
        dec_b.dest  = rd;
        dec_b.wr_en = 1'b1;
      end
      OPC_SET: begin
        dec_b.op    = alu_op_e'({2'b01, opc[1:0]});
        dec_b.data1 = rs_val;
        dec_b.data2 = rt_val;
        dec_b.dest  = rd;
        dec_b.wr_en = 1'b1;
      end
      OPC_IMM: begin
        // ADDI/SUBI sign-extend; XORI/ANDNI (opc[1]=1) zero-extend
        dec_b.op    = alu_family(opc[1:0]);
        dec_b.data1 = rs_val;
        dec_b.data2 = opc[1] ? {{(DATA_W-IMM5_W){1'b0}}, imm5}
                             : {{(DATA_W-IMM5_W){imm5[IMM5_W-1]}}, imm5};
        dec_b.dest  = rt;
        dec_b.wr_en = 1'b1;
      end
      OPC_SLBI: begin
        dec_b.op    = ALU_SLB;
        dec_b.data1 = rs_val;
        dec_b.data2 = {{(DATA_W-IMM8_W){1'b0}}, imm8};
        dec_b.dest  = rs;
        dec_b.wr_en = 1'b1;
      end
      OPC_BTR: begin
        dec_b.op    = ALU_BTR;
        dec_b.data1 = rs_val;
        dec_b.dest  = rd;
        dec_b.wr_en = 1'b1;
      end
      OPC_NOP: begin
      end
      default: begin
        dec_b.illegal = 1'b1;
      end
    endcase
  end

  occ_state_e state, state_nxt;
  logic       accept;
  logic       ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = (state == ST_EMPTY) || bus.out_ready;
    accept    = bus.in_valid && ready_c;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (!accept && bus.out_ready) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Operands are captured once at accept; a stalled bundle never re-reads the file
  bundle_t out_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_b <= '0;
    else if (accept) out_b <= dec_b;
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = (state == ST_FULL);
  assign bus.op        = out_b.op;
  assign bus.data1     = out_b.data1;
  assign bus.data2     = out_b.data2;
  assign bus.dest      = out_b.dest;
  assign bus.wr_en     = out_b.wr_en;
  assign bus.illegal   = out_b.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed vector table, hand-written
// handshake/reset/bypass sequences and randomized traffic against a reference model.
module tb_decode_issue;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  dest;
    logic        wr;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [15:0] instr;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst_n;

  decode_issue_if bus ();

  decode_issue #(
    .DATA_W (16),
    .NREGS  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] mregs [8];
  logic        exp_valid;
  exp_t        exp_b;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int unsigned opc, input int unsigned rs,
                                     input int unsigned rt, input int unsigned rd,
                                     input int unsigned fn);
    return {5'(opc), 3'(rs), 3'(rt), 3'(rd), 2'(fn)};
  endfunction

  function automatic logic [15:0] mkimm(input int unsigned opc, input int unsigned rs,
                                        input int unsigned rt, input int unsigned imm);
    return {5'(opc), 3'(rs), 3'(rt), 5'(imm)};
  endfunction

  // Reference decode straight from the ISA rules, using integer opcode ranges
  function automatic exp_t ref_decode(input logic [15:0] ins);
    exp_t r;
    int unsigned opc, rs, rt, rd, fn, imm5, k;
    logic [15:0] a, b;
    opc  = 32'(ins[15:11]);
    rs   = 32'(ins[10:8]);
    rt   = 32'(ins[7:5]);
    rd   = 32'(ins[4:2]);
    fn   = 32'(ins[1:0]);
    imm5 = 32'(ins[4:0]);
    a = mregs[rs];
    b = mregs[rt];
`ifdef DECODE_BYPASS_EN
    if (bus.wb_en && 32'(bus.wb_reg) == rs) a = bus.wb_data;
    if (bus.wb_en && 32'(bus.wb_reg) == rt) b = bus.wb_data;
`endif
    r = '0;
    if (opc == 27) begin
      r.op = (fn == 3) ? 4'd12 : 4'(fn);
      r.d1 = a; r.d2 = b; r.dest = 3'(rd); r.wr = 1'b1;
    end else if (opc == 26) begin
      r.op = 4'(8 + fn);
      r.d1 = a; r.d2 = b; r.dest = 3'(rd); r.wr = 1'b1;
    end else if (opc >= 28) begin
      r.op = 4'(4 + opc - 28);
      r.d1 = a; r.d2 = b; r.dest = 3'(rd); r.wr = 1'b1;
    end else if (opc >= 8 && opc <= 11) begin
      k = opc - 8;
      r.op = (k == 3) ? 4'd12 : 4'(k);
      r.d1 = a;
      r.d2 = (k <= 1 && imm5 >= 16) ? 16'(imm5 + 65536 - 32) : 16'(imm5);
      r.dest = 3'(rt); r.wr = 1'b1;
    end else if (opc == 18) begin
      r.op = 4'd13; r.d1 = a; r.d2 = 16'(ins & 16'h00FF); r.dest = 3'(rs); r.wr = 1'b1;
    end else if (opc == 25) begin
      r.op = 4'd14; r.d1 = a; r.d2 = 16'h0000; r.dest = 3'(rd); r.wr = 1'b1;
    end else if (opc == 1) begin
      r = '0;
    end else begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic cmp_model();
    chk("out_valid", 16'(bus.out_valid), 16'(exp_valid));
    if (exp_valid) begin
      chk("op",      16'(bus.op),      16'(exp_b.op));
      chk("data1",   bus.data1,        exp_b.d1);
      chk("data2",   bus.data2,        exp_b.d2);
      chk("dest",    16'(bus.dest),    16'(exp_b.dest));
      chk("wr_en",   16'(bus.wr_en),   16'(exp_b.wr));
      chk("illegal", 16'(bus.illegal), 16'(exp_b.ill));
    end
  endtask

  // Inputs are already driven (posedge+1); check in_ready, clock, then advance the model
  task automatic step();
    logic acc;
    #1;
    chk("in_ready", 16'(bus.in_ready), 16'(!exp_valid || bus.out_ready));
    @(posedge clk);
    #1;
    acc = bus.in_valid && (!exp_valid || bus.out_ready);
    if (acc) begin
      exp_b     = ref_decode(bus.instr);
      exp_valid = 1'b1;
    end else if (bus.out_ready) begin
      exp_valid = 1'b0;
    end
    if (bus.wb_en) mregs[bus.wb_reg] = bus.wb_data;
    cmp_model();
  endtask

  task automatic wb_write(input int unsigned r, input logic [15:0] v);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.wb_en = 1'b1;
    bus.wb_reg = 3'(r);
    bus.wb_data = v;
    step();
    bus.wb_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins);
    bus.instr = ins;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
    chk({tag, "_op"},    16'(bus.op),        16'(e.op));
    chk({tag, "_d1"},    bus.data1,          e.d1);
    chk({tag, "_d2"},    bus.data2,          e.d2);
    chk({tag, "_dest"},  16'(bus.dest),      16'(e.dest));
    chk({tag, "_wr"},    16'(bus.wr_en),     16'(e.wr));
    chk({tag, "_ill"},   16'(bus.illegal),   16'(e.ill));
  endtask

  vec_t vecs [16];
  logic [4:0] legal_opc [9];

  initial begin
    // Vector table; register i holds 16'h1111*(i+1) when these are issued
    vecs[0]  = '{mk(27,1,2,3,0), '{4'd0,  16'h2222, 16'h3333, 3'd3, 1'b1, 1'b0}};
    vecs[1]  = '{mk(27,4,5,6,1), '{4'd1,  16'h5555, 16'h6666, 3'd6, 1'b1, 1'b0}};
    vecs[2]  = '{mk(27,0,7,1,2), '{4'd2,  16'h1111, 16'h8888, 3'd1, 1'b1, 1'b0}};
    vecs[3]  = '{mk(27,3,3,7,3), '{4'd12, 16'h4444, 16'h4444, 3'd7, 1'b1, 1'b0}};
    vecs[4]  = '{mk(26,2,1,5,0), '{4'd8,  16'h3333, 16'h2222, 3'd5, 1'b1, 1'b0}};
    vecs[5]  = '{mk(26,6,0,2,3), '{4'd11, 16'h7777, 16'h1111, 3'd2, 1'b1, 1'b0}};
    vecs[6]  = '{mk(28,1,2,3,0), '{4'd4,  16'h2222, 16'h3333, 3'd3, 1'b1, 1'b0}};
    vecs[7]  = '{mk(31,5,4,0,2), '{4'd7,  16'h6666, 16'h5555, 3'd0, 1'b1, 1'b0}};
    vecs[8]  = '{mkimm(8,2,4,17), '{4'd0,  16'h3333, 16'hFFF1, 3'd4, 1'b1, 1'b0}};
    vecs[9]  = '{mkimm(11,7,1,31),'{4'd12, 16'h8888, 16'h001F, 3'd1, 1'b1, 1'b0}};
    vecs[10] = '{16'h94A5,        '{4'd13, 16'h5555, 16'h00A5, 3'd4, 1'b1, 1'b0}};
    vecs[11] = '{mk(25,6,3,2,1), '{4'd14, 16'h7777, 16'h0000, 3'd2, 1'b1, 1'b0}};
    vecs[12] = '{16'h0800,        '{4'd0,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0}};
    vecs[13] = '{16'h0000,        '{4'd0,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1}};
    vecs[14] = '{16'h9FFF,        '{4'd0,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1}};
    vecs[15] = '{mkimm(9,0,5,7),  '{4'd1,  16'h1111, 16'h0007, 3'd5, 1'b1, 1'b0}};

    legal_opc = '{5'b11011, 5'b11010, 5'b11100, 5'b11111, 5'b01000,
                  5'b01011, 5'b10010, 5'b11001, 5'b00001};

    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    exp_valid     = 1'b0;
    exp_b         = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = 16'h0000;
    bus.out_ready = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_reg    = 3'd0;
    bus.wb_data   = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_op",        16'(bus.op),        16'd0);
    chk("rst_data1",     bus.data1,          16'h0000);
    chk("rst_data2",     bus.data2,          16'h0000);
    chk("rst_dest",      16'(bus.dest),      16'd0);
    chk("rst_wr_en",     16'(bus.wr_en),     16'd0);
    chk("rst_illegal",   16'(bus.illegal),   16'd0);
    chk("rst_in_ready",  16'(bus.in_ready),  16'd1);
    rst_n = 1'b1;

    // Directed table
    for (int unsigned i = 0; i < 8; i++) wb_write(i, 16'(16'h1111 * (i + 1)));
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].instr);
      chk_out($sformatf("vec%0d", i), vecs[i].e);
    end

    // ALU path and immediate extension
    wb_write(1, 16'h0003);
    wb_write(2, 16'h0005);
    issue(mk(27,1,2,3,1));
    chk_out("sub", '{4'd1, 16'h0003, 16'h0005, 3'd3, 1'b1, 1'b0});
    issue(mkimm(9,1,0,30));
    chk_out("subi", '{4'd1, 16'h0003, 16'hFFFE, 3'd0, 1'b1, 1'b0});
    issue(mkimm(10,1,2,30));
    chk_out("xori", '{4'd2, 16'h0003, 16'h001E, 3'd2, 1'b1, 1'b0});

    // Backpressure: bundle A held 3 cycles while B waits; R1 rewritten mid-stall
    issue(mk(27,1,2,6,0));
    bus.instr = mk(27,2,1,7,1);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wb_en = (i == 1);
      bus.wb_reg = 3'd1;
      bus.wb_data = 16'h0999;
      step();
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
      chk_out("bp_hold", '{4'd0, 16'h0003, 16'h0005, 3'd6, 1'b1, 1'b0});
    end
    bus.wb_en = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk_out("bp_next", '{4'd1, 16'h0005, 16'h0999, 3'd7, 1'b1, 1'b0});
    bus.in_valid = 1'b0;
    step();
    chk("bp_drain", 16'(bus.out_valid), 16'd0);

    // Same-cycle writeback and read of R2
    wb_write(2, 16'h00AA);
    bus.wb_en = 1'b1;
    bus.wb_reg = 3'd2;
    bus.wb_data = 16'h1234;
    issue(mk(27,2,0,1,0));
    bus.wb_en = 1'b0;
`ifdef DECODE_BYPASS_EN
    chk("bypass_d1", bus.data1, 16'h1234);
`else
    chk("bypass_d1", bus.data1, 16'h00AA);
`endif

    // Reset while a bundle is stalled
    wb_write(5, 16'hBEEF);
    bus.instr = mk(27,5,5,3,0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    exp_valid = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    chk("mrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("mrst_op",        16'(bus.op),        16'd0);
    chk("mrst_data1",     bus.data1,          16'h0000);
    chk("mrst_dest",      16'(bus.dest),      16'd0);
    chk("mrst_wr_en",     16'(bus.wr_en),     16'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(16'hDDAC);
    chk_out("post_rst", '{4'd0, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b0});

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ins[15:11] = legal_opc[$urandom_range(0, 8)];
      bus.instr     = ins;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.wb_en     = ($urandom_range(0, 1) != 0);
      bus.wb_reg    = 3'($urandom_range(0, 7));
      bus.wb_data   = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Front end feeding the 16-bit ALU execute stage.
- Accepts one 16-bit instruction per handshake and reads two operands from an internal 8x16 register file.
- Translates the instruction into the 4-bit ALU op encoding, then presents op/data1/data2/dest in a registered output stage with valid/ready.
- Also owns the register-file write port that receives writeback results.

Parameters:
DATA_W, 16, datapath and register width
NREGS, 8, register count (3-bit register fields; fixed by ISA)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  decoder can accept instruction
instr  in  16  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute stage consumes bundle
op  out  4  ALU op code
data1  out  16  ALU operand 1
data2  out  16  ALU operand 2
dest  out  3  destination register
wr_en  out  1  result is to be written back
illegal  out  1  undefined opcode flag
wb_en  in  1  writeback strobe
wb_reg  in  3  writeback register index
wb_data  in  16  writeback value

Behaviour:
- Reset (async on rst_n low):
  - out_valid, op, data1, data2, dest, wr_en and illegal clear to 0.
  - All 8 registers clear to 0.
  - Reset mid-transfer discards the held bundle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Instruction accepted when in_valid && in_ready.
  - Output register loads on the accept edge; out_valid=1 the next cycle (latency 1).
  - If out_ready && out_valid && !accept, out_valid clears.
  - While out_valid && !out_ready, all outputs hold stable.
- Fields:
  - opc=instr[15:11], rs=[10:8], rt=[7:5], rd=[4:2], fn=[1:0].
  - imm5=[4:0], imm8=[7:0].
- ALU op encoding:
  - 0 add (d1+d2), 1 sub (d2-d1), 2 xor, 3 and.
  - 4..7 SEQ/SLT/SLE/SCO.
  - 8..11 ROL/SLL/ROR/SRL.
  - 12 ANDN, 13 SLB, 14 BTR; 15 reserved (never emitted).
- Decode table:
  - 11011 (R-ALU): fn 00/01/10/11 -> op 0/1/2/12. d1=R[rs], d2=R[rt], dest=rd, wr_en=1.
  - 11010 (R-shift): fn -> op 8+fn. d1=R[rs], d2=R[rt], dest=rd, wr_en=1.
  - 111ff (set): op 4+opc[1:0]. d1=R[rs], d2=R[rt], dest=rd, wr_en=1.
  - 010ff (imm ALU): ADDI/SUBI/XORI/ANDNI -> op 0/1/2/12. d1=R[rs], dest=rt, wr_en=1. d2 = sign-extended imm5 for ADDI/SUBI, zero-extended imm5 for XORI/ANDNI.
  - 10010 (SLBI): op 13. d1=R[rs], d2 = zero-extended imm8, dest=rs, wr_en=1.
  - 11001 (BTR): op 14. d1=R[rs], d2=0, dest=rd, wr_en=1.
  - 00001 (NOP): op 0, d1=d2=0, dest=0, wr_en=0, illegal=0.
  - Any other opcode: illegal=1, wr_en=0, op=0, d1=d2=0, dest=0. Still handshaked normally.
- Register file:
  - Writes on the clk edge when wb_en; R0 is an ordinary register.
  - Reads are combinational at the accept cycle.
  - wb independent of the handshake; writes occur even while the output is stalled.
  - A stalled bundle keeps its captured operand values (no re-read).

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: when wb_en and wb_reg equals a source index in the accept cycle, that operand takes wb_data (write-through).
- Undefined: the operand takes the pre-write register value; software must separate dependent instructions.

Decomposition:
- Shared package holds:
  - ALU op constants 0..14, shared with the execute stage.
  - Opcode constants (5-bit).
  - Field position constants.
  - Decoded-bundle struct typedef {op, data1, data2, dest, wr_en, illegal}.
- One sub-module: decode_regfile (8x16, 2 async read, 1 sync write, bypass under DECODE_BYPASS_EN).

Test Plan:
- Reset: rst_n low mid-stream -> out_valid=0, all outputs 0. Reading R5 via ADD 11011_101_101_011_00 after release -> data1=data2=0.
- ALU path: wb R1=0x0003, R2=0x0005; issue SUB rs=1, rt=2, rd=3 -> next cycle out_valid=1, op=1, data1=3, data2=5, dest=3, wr_en=1.
- Imm extension:
  - SUBI rs=1, imm5=5'b11110 -> d2=0xFFFE, op=1.
  - XORI imm5=5'b11110 -> d2=0x001E, op=2.
  - SLBI rs=4, imm8=0xA5 -> op=13, d2=0x00A5, dest=4.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen. out_ready=1 -> next instruction loads the following edge, no loss or duplication.
- Bypass: same cycle wb R2=0x1234 and accept ADD rs=2 -> data1=0x1234 with DECODE_BYPASS_EN, old R2 without.
- Illegal: instr 0x0000 -> illegal=1, wr_en=0, op=0. NOP 0x0800 -> illegal=0, wr_en=0.
